async_receiver: RTL and testbench



---
 rtl/async_receiver.sv | 217 +++++++++++++++++++++
 tb/tb_async_receiver.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/async_receiver.sv
`timescale 1ns / 1ps
// async_receiver: UART receive block for the Bluetooth UART link (BT_UART_RX pin).
// Oversamples RxD with a fractional-accumulator baud generator, filters it, and
// deserialises 8N1 frames LSB first. Each good byte is presented with a one-cycle
// strobe for the RX FIFO write side; a low stop bit raises a one-cycle error strobe.
//
// Ports:
//   clk             system clock (uart_clk_25m)
//   rst_n           asynchronous active-low reset
//   RxD             serial line, idle high, asynchronous to clk
//   RxD_data        last good byte, held until the next good frame
//   RxD_data_ready  one-cycle strobe, RxD_data valid
//   RxD_frame_err   one-cycle strobe, stop bit sampled low
//   RxD_busy        high while a frame (or a held-low break) is in progress
//   RxD_parity_err  one-cycle strobe with RxD_data_ready on an even-parity
//                   mismatch (only with UART_RX_PARITY_EN defined)
//
// Optional feature: define UART_RX_PARITY_EN for 8E1 frames (extra PARITY state).
module async_receiver #(
    parameter int unsigned ClkFrequency          = 25000000,
    parameter int unsigned Baud                  = 115200,
    parameter int unsigned Oversampling          = 8,
    parameter int unsigned BaudGeneratorAccWidth = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RxD,
    output logic [7:0] RxD_data,
    output logic       RxD_data_ready,
    output logic       RxD_frame_err,
`ifdef UART_RX_PARITY_EN
    output logic       RxD_parity_err,
`endif
    output logic       RxD_busy
);

    localparam int unsigned AccW = BaudGeneratorAccWidth;
    localparam int unsigned TmrW = $clog2(Oversampling);
    // Rounded-shift form keeps Baud*Oversampling*2^AccW/ClkFrequency inside 32 bits.
    localparam int unsigned IncWide =
        (((Baud * Oversampling) << (AccW - 7)) + (ClkFrequency >> 8)) / (ClkFrequency >> 7);
    localparam logic [AccW:0] Inc     = (AccW + 1)'(IncWide);
    localparam logic [TmrW-1:0] TmrHalf = TmrW'(Oversampling / 2 - 1);
    localparam logic [TmrW-1:0] TmrLast = TmrW'(Oversampling - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_RX_PARITY_EN
        StParity,
`endif
        StStop,
        StBreak
    } state_e;

    logic [AccW:0]   acc_q, acc_d;
    logic            tick;
    logic [1:0]      sync_q;
    logic [1:0]      cnt_q, cnt_d;
    logic            filt_q, filt_d;
    state_e          state_q, state_d;
    logic [TmrW-1:0] tmr_q, tmr_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            ready_q, ready_d;
    logic            ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
    logic            par_q, par_d;
    logic            perr_q, perr_d;
`endif

    // Carry out of the accumulator is the tick; dropping it on the next add clears it.
    assign acc_d = {1'b0, acc_q[AccW-1:0]} + Inc;
    assign tick  = acc_q[AccW];

    // Saturating 2-bit filter: the filtered bit only flips at the rails.
    always_comb begin
        cnt_d = cnt_q;
        if (tick) begin
            if (sync_q[1] && cnt_q != 2'd3) begin
                cnt_d = cnt_q + 2'd1;
            end else if (!sync_q[1] && cnt_q != 2'd0) begin
                cnt_d = cnt_q - 2'd1;
            end
        end
        filt_d = filt_q;
        if (cnt_d == 2'd3) begin
            filt_d = 1'b1;
        end else if (cnt_d == 2'd0) begin
            filt_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        tmr_d   = tick ? tmr_q + 1'b1 : tmr_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        ready_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                if (tick && !filt_q) begin
                    state_d = StStart;
                    tmr_d   = '0;
                end
            end
            StStart: begin
                // Half-bit resample rejects glitches and aligns the timer to bit centres.
                if (tick && tmr_q == TmrHalf) begin
                    tmr_d   = '0;
                    idx_d   = 3'd0;
                    state_d = filt_q ? StIdle : StData;
                end
            end
            StData: begin
                if (tick && tmr_q == TmrLast) begin
                    tmr_d   = '0;
                    shift_d = {filt_q, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (tick && tmr_q == TmrLast) begin
                    tmr_d   = '0;
                    par_d   = filt_q;
                    state_d = StStop;
                end
            end
`endif
            StStop: begin
                if (tick && tmr_q == TmrLast) begin
                    tmr_d = '0;
                    if (filt_q) begin
                        data_d  = shift_q;
                        ready_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                        perr_d  = par_q ^ (^shift_q);
`endif
                        state_d = StIdle;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = StBreak;
                    end
                end
            end
            StBreak: begin
                // Hold here while the line stays low so a break cannot re-trigger.
                if (filt_q) begin
                    tmr_d   = '0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            sync_q  <= 2'b11;
            cnt_q   <= 2'd3;
            filt_q  <= 1'b1;
            state_q <= StIdle;
            tmr_q   <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            data_q  <= 8'h00;
            ready_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            acc_q   <= acc_d;
            sync_q  <= {sync_q[0], RxD};
            cnt_q   <= cnt_d;
            filt_q  <= filt_d;
            state_q <= state_d;
            tmr_q   <= tmr_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    assign RxD_data       = data_q;
    assign RxD_data_ready = ready_q;
    assign RxD_frame_err  = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign RxD_parity_err = perr_q;
`endif
    assign RxD_busy       = (state_q != StIdle);

endmodule

// File: tb/tb_async_receiver.sv
`timescale 1ns / 1ps
// Bench for async_receiver: frames are driven at 115200 baud (217 clk per bit at 25 MHz).
// The frame model pushes the expected strobe into a queue; a monitor pops and compares
// whenever the DUT raises RxD_data_ready or RxD_frame_err.
module tb_async_receiver;

    localparam int BitClk  = 217;
    localparam int Os      = 8;
    localparam int TickClk = 28;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       RxD = 1'b1;
    logic [7:0] RxD_data;
    logic       RxD_data_ready;
    logic       RxD_frame_err;
    logic       RxD_busy;
`ifdef UART_RX_PARITY_EN
    logic       RxD_parity_err;
`endif

    async_receiver dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .RxD           (RxD),
        .RxD_data      (RxD_data),
        .RxD_data_ready(RxD_data_ready),
        .RxD_frame_err (RxD_frame_err),
`ifdef UART_RX_PARITY_EN
        .RxD_parity_err(RxD_parity_err),
`endif
        .RxD_busy      (RxD_busy)
    );

    always #20 clk = ~clk;

    typedef struct packed {
        logic       is_err;
        logic [7:0] data;
        logic       perr;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] last_good = 8'h00;
    logic       prev_strobe = 1'b0;
    logic       strobe;
    exp_t       got_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic v);
        RxD = v;
        repeat (BitClk) @(posedge clk);
    endtask

    // Reference frame model: a good stop bit delivers the byte, a low one reports an error
    // and leaves the held data at the last good byte.
    task automatic send_frame(input logic [7:0] d, input logic stop_ok, input logic par_ok);
        exp_t e;
        if (stop_ok) begin
            e.is_err  = 1'b0;
            e.data    = d;
`ifdef UART_RX_PARITY_EN
            e.perr    = !par_ok;
`else
            e.perr    = 1'b0;
`endif
            last_good = d;
        end else begin
            e.is_err = 1'b1;
            e.data   = last_good;
            e.perr   = 1'b0;
        end
        exp_q.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par_ok ? ^d : ~^d);
`endif
        drive_bit(stop_ok);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 4000) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d strobes still outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (4) @(posedge clk);
    endtask

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            strobe = RxD_data_ready | RxD_frame_err;
            if (strobe) begin
                checks++;
                if ((RxD_data_ready && RxD_frame_err) || prev_strobe) begin
                    errors++;
                    $display("FAIL strobe_shape: ready=%0b ferr=%0b prev=%0b, expected single pulse",
                             RxD_data_ready, RxD_frame_err, prev_strobe);
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_strobe: ready=%0b ferr=%0b data=0x%0h, expected none",
                             RxD_data_ready, RxD_frame_err, RxD_data);
                end else begin
                    got_e = exp_q.pop_front();
                    if (RxD_frame_err !== got_e.is_err || RxD_data !== got_e.data
`ifdef UART_RX_PARITY_EN
                        || RxD_parity_err !== got_e.perr
`endif
                    ) begin
                        errors++;
                        $display("FAIL strobe_content: ferr=%0b data=0x%0h perr=%0b expected ferr=%0b data=0x%0h perr=%0b",
                                 RxD_frame_err, RxD_data,
`ifdef UART_RX_PARITY_EN
                                 RxD_parity_err,
`else
                                 1'b0,
`endif
                                 got_e.is_err, got_e.data, got_e.perr);
                    end
                end
            end
            prev_strobe = strobe;
        end else begin
            prev_strobe = 1'b0;
        end
    end

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic       stop_ok;
        logic       par_ok;
        int         gap;

        // Reset state.
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("reset_data", {24'd0, RxD_data}, 32'd0);
        check("reset_ready", {31'd0, RxD_data_ready}, 32'd0);
        check("reset_ferr", {31'd0, RxD_frame_err}, 32'd0);
        check("reset_busy", {31'd0, RxD_busy}, 32'd0);
        @(posedge clk);
        rst_n = 1'b1;
        repeat (2 * BitClk) @(posedge clk);

        // Single frame.
        send_frame(8'h55, 1'b1, 1'b1);
        wait_drain("frame_55");

        // Back-to-back frames, single stop bit each.
        send_frame(8'h00, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b1);
        send_frame(8'hA3, 1'b1, 1'b1);
        wait_drain("back_to_back");
        check("held_data", {24'd0, RxD_data}, 32'h0000_00A3);

        // Short low glitch on an idle line.
        repeat (BitClk) @(posedge clk);
        RxD = 1'b0;
        repeat (2) @(posedge clk);
        RxD = 1'b1;
        repeat ((Os / 2 + 2) * TickClk + 8) @(posedge clk);
        @(negedge clk);
        check("glitch_busy", {31'd0, RxD_busy}, 32'd0);
        repeat (12 * BitClk) @(posedge clk);

        // Bad stop bit, line held low, then a good frame.
        send_frame(8'h3C, 1'b0, 1'b1);
        repeat (3) drive_bit(1'b0);
        drive_bit(1'b1);
        wait_drain("frame_err");
        check("ferr_held_data", {24'd0, RxD_data}, 32'h0000_00A3);
        send_frame(8'h81, 1'b1, 1'b1);
        wait_drain("after_break");

        // Reset in the middle of BIT4.
        d = 8'h7E;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        RxD = d[4];
        repeat (BitClk / 2) @(posedge clk);
        rst_n = 1'b0;
        last_good = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("midreset_data", {24'd0, RxD_data}, 32'd0);
        check("midreset_ready", {31'd0, RxD_data_ready}, 32'd0);
        check("midreset_busy", {31'd0, RxD_busy}, 32'd0);
        @(posedge clk);
        RxD   = 1'b1;
        rst_n = 1'b1;
        repeat (12 * BitClk) @(posedge clk);
        check("no_strobe_aborted", exp_q.size(), 32'd0);
        send_frame(8'h7E, 1'b1, 1'b1);
        wait_drain("after_reset");

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1);
        send_frame(8'h07, 1'b1, 1'b0);
        wait_drain("parity");
`endif

        // Randomised frames with occasional bad stop bits and varying idle gaps.
        for (int n = 0; n < 6; n++) begin
            d       = 8'($urandom);
            stop_ok = ($urandom_range(0, 4) != 0);
            par_ok  = ($urandom_range(0, 3) != 0);
            send_frame(d, stop_ok, par_ok);
            if (!stop_ok) begin
                repeat (2) drive_bit(1'b0);
                drive_bit(1'b1);
            end
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) drive_bit(1'b1);
        end
        wait_drain("random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
